axil_cfg_slave: RTL and testbench

- AXI-Lite slave register block; directly downstream of the Wishbone-to-AXI-Lite bridge in the user project area.
- Decodes bridge writes and reads into three things: an ap_ctrl block-level control register, a data_length register, and a tap-coefficient BRAM port.
- Drives start to the compute engine and collects its done pulse.
- Absorbs the bridge's behaviour: the bridge holds awvalid and wvalid together until wready, and holds arvalid and rready together.

---
 rtl/axil_cfg_pkg.sv | 30 +++
 rtl/axil_cfg_slave.sv | 202 ++++++++++++++++++++
 tb/tb_axil_cfg_slave.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cfg_pkg.sv
// Shared definitions for the AXI-Lite configuration slave: the address map,
// the ap_ctrl bit layout and the handshake FSM state encoding.
package axil_cfg_pkg;

    localparam int ADDR_AP_CTRL  = 'h00;
    localparam int ADDR_DATA_LEN = 'h10;
    localparam int ADDR_TAP_BASE = 'h40;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ACK,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_DATA
    } cfg_state_e;

    // ap_start is a write-only strobe, so it always reads back as 0.
    function automatic logic [31:0] pack_ap_ctrl(input logic done, input logic idle);
        logic [31:0] word;
        word              = '0;
        word[AP_DONE_BIT] = done;
        word[AP_IDLE_BIT] = idle;
        return word;
    endfunction

endpackage

// File: rtl/axil_cfg_slave.sv
// AXI-Lite register slave behind the Wishbone bridge: ap_ctrl, data_length and
// the tap-coefficient BRAM port, with a single FSM serialising writes and reads.
module axil_cfg_slave
    import axil_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start_o,
    output logic [31:0]            data_length_o,
    input  logic                   engine_done_i
);

    localparam logic [pADDR_WIDTH-1:0] AP_CTRL_A  = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] DATA_LEN_A = pADDR_WIDTH'(ADDR_DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE_A = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST_A = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * (Tape_Num - 1));
    localparam logic [pDATA_WIDTH-1:0] BUSY_WORD  = '1;

    cfg_state_e state_q, state_d;

    logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                   rd_blocked_q, rd_blocked_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]            data_length_q, data_length_d;
    logic                   ap_done_q, ap_done_d;
    logic                   ap_idle_q, ap_idle_d;
    logic                   ap_start_q, ap_start_d;

    logic [pADDR_WIDTH-1:0] wr_word;
    logic [pADDR_WIDTH-1:0] rd_word;
    logic                   wr_is_tap;
    logic                   rd_is_tap;
    logic                   raddr_is_tap;
    logic                   wr_fire;
    logic                   start_accept;
    logic                   ctrl_read;
    logic [pDATA_WIDTH-1:0] rd_mux;
    logic                   unused_addr_bits;

    // Byte-lane bits are ignored; every access is treated as a full word.
    assign wr_word          = {awaddr[pADDR_WIDTH-1:2], 2'b00};
    assign rd_word          = {araddr[pADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    assign wr_is_tap    = (wr_word >= TAP_BASE_A) && (wr_word <= TAP_LAST_A);
    assign rd_is_tap    = (rd_word >= TAP_BASE_A) && (rd_word <= TAP_LAST_A);
    assign raddr_is_tap = (raddr_q >= TAP_BASE_A) && (raddr_q <= TAP_LAST_A);

    assign wr_fire      = (state_q == ST_WR_ACK);
    assign start_accept = wr_fire && (wr_word == AP_CTRL_A) && wdata[AP_START_BIT] && ap_idle_q;
    assign ctrl_read    = (state_q == ST_RD_WAIT) && (raddr_q == AP_CTRL_A);

    assign awready       = wr_fire;
    assign wready        = wr_fire;
    assign arready       = (state_q == ST_RD_ISSUE);
    assign rvalid        = (state_q == ST_RD_DATA);
    assign rdata         = rdata_q;
    assign ap_start_o    = ap_start_q;
    assign data_length_o = data_length_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (awvalid && wvalid) begin
                    state_d = ST_WR_ACK;
                end else if (arvalid) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_WR_ACK:   state_d = ST_IDLE;
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT:  state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (rready) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // BRAM port is shared by the write acknowledge and the read issue cycles.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (wr_fire && wr_is_tap && ap_idle_q) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = wr_word - TAP_BASE_A;
            tap_Di = wdata;
        end else if ((state_q == ST_RD_ISSUE) && rd_is_tap && ap_idle_q) begin
            tap_EN = 1'b1;
            tap_A  = rd_word - TAP_BASE_A;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (raddr_q == AP_CTRL_A) begin
            rd_mux = pDATA_WIDTH'(pack_ap_ctrl(ap_done_q, ap_idle_q));
        end else if (raddr_q == DATA_LEN_A) begin
            rd_mux = rd_blocked_q ? BUSY_WORD : pDATA_WIDTH'(data_length_q);
        end else if (raddr_is_tap) begin
            rd_mux = rd_blocked_q ? BUSY_WORD : tap_Do;
        end
    end

    // The busy decision is frozen at address accept so tap_EN and the returned
    // data agree even if the engine finishes while the read is in flight.
    always_comb begin
        raddr_d      = raddr_q;
        rd_blocked_d = rd_blocked_q;
        rdata_d      = rdata_q;
        if (state_q == ST_RD_ISSUE) begin
            raddr_d      = rd_word;
            rd_blocked_d = !ap_idle_q;
        end
        if (state_q == ST_RD_WAIT) begin
            rdata_d = rd_mux;
        end
    end

    // A done pulse wins over both clear-on-read and a start in the same cycle.
    always_comb begin
        data_length_d = data_length_q;
        ap_start_d    = start_accept;
        ap_done_d     = ap_done_q;
        ap_idle_d     = ap_idle_q;
        if (wr_fire && (wr_word == DATA_LEN_A) && ap_idle_q) begin
            data_length_d = 32'(wdata);
        end
        if (ctrl_read) begin
            ap_done_d = 1'b0;
        end
        if (start_accept) begin
            ap_idle_d = 1'b0;
        end
        if (engine_done_i) begin
            ap_done_d = 1'b1;
            ap_idle_d = 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            raddr_q      <= '0;
            rd_blocked_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            raddr_q      <= raddr_d;
            rd_blocked_q <= rd_blocked_d;
            rdata_q      <= rdata_d;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            data_length_q <= '0;
            ap_start_q    <= 1'b0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
        end else begin
            data_length_q <= data_length_d;
            ap_start_q    <= ap_start_d;
            ap_done_q     <= ap_done_d;
            ap_idle_q     <= ap_idle_d;
        end
    end

endmodule

// File: tb/tb_axil_cfg_slave.sv
// Directed bench for axil_cfg_slave: a vector table for simple accesses plus
// hand-written sequences for taps, start/done handling, arbitration and reset.
module tb_axil_cfg_slave;

    logic        clk;
    logic        rst_n;
    logic        awvalid, wvalid, arvalid, rready;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [11:0] tap_A;
    logic [31:0] tap_Di, tap_Do;
    logic        ap_start_o;
    logic [31:0] data_length_o;
    logic        engine_done_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int tap_en_cnt = 0;

    logic [31:0] tap_mem [0:15];

    axil_cfg_slave #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk      (clk),
        .axis_rst_n    (rst_n),
        .awvalid       (awvalid),
        .awready       (awready),
        .awaddr        (awaddr),
        .wvalid        (wvalid),
        .wready        (wready),
        .wdata         (wdata),
        .arvalid       (arvalid),
        .arready       (arready),
        .araddr        (araddr),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .tap_WE        (tap_WE),
        .tap_EN        (tap_EN),
        .tap_A         (tap_A),
        .tap_Di        (tap_Di),
        .tap_Do        (tap_Do),
        .ap_start_o    (ap_start_o),
        .data_length_o (data_length_o),
        .engine_done_i (engine_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tap BRAM with one-cycle registered read.
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= tap_mem[tap_A[5:2]];
        end
        if (tap_EN) tap_en_cnt <= tap_en_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output int lat,
                             output logic en_s, output logic [3:0] we_s,
                             output logic [11:0] ta_s, output logic [31:0] di_s);
        lat = -1; en_s = 1'b0; we_s = 4'h0; ta_s = '0; di_s = '0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (awready && wready) begin
                lat = c; en_s = tap_EN; we_s = tap_WE; ta_s = tap_A; di_s = tap_Di;
                @(posedge clk); #1;
                break;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        $display("WR addr=0x%03h data=0x%08h lat=%0d tapEN=%0b tapWE=%h tapA=0x%03h",
                 a, d, lat, en_s, we_s, ta_s);
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold, input int done_at,
                            output logic [31:0] d, output int lat, output bit proto_ok);
        lat = -1; d = '0; proto_ok = 1'b1;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            engine_done_i = (c == done_at);
            if (rvalid) begin
                lat = c; d = rdata;
                break;
            end
        end
        engine_done_i = 1'b0;
        if (lat > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (!rvalid || rdata !== d) proto_ok = 1'b0;
            end
            rready = 1'b1;
            @(posedge clk); #1;
            if (rvalid) proto_ok = 1'b0;
        end
        arvalid = 1'b0; rready = 1'b0;
        $display("RD addr=0x%03h data=0x%08h lat=%0d proto_ok=%0b", a, d, lat, proto_ok);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          lat;
        logic        en_s;
        logic [3:0]  we_s;
        logic [11:0] ta_s;
        logic [31:0] di_s, rd;
        bit          ok;
        int          en_before;
        int          wr_cyc, rv_cyc;
        logic        ar_early;

        vecs[0] = '{1'b0, 12'h000, 32'h0,        32'h0000_0004};
        vecs[1] = '{1'b1, 12'h010, 32'h0000_0258, 32'h0};
        vecs[2] = '{1'b0, 12'h010, 32'h0,        32'h0000_0258};
        vecs[3] = '{1'b1, 12'h004, 32'h0000_DEAD, 32'h0};
        vecs[4] = '{1'b0, 12'h004, 32'h0,        32'h0000_0000};
        vecs[5] = '{1'b0, 12'h013, 32'h0,        32'h0000_0258};
        vecs[6] = '{1'b0, 12'h06C, 32'h0,        32'h0000_0000};

        for (int i = 0; i < 16; i++) tap_mem[i] = '0;
        tap_Do = '0;
        rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; engine_done_i = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_handshakes", {28'h0, awready, wready, arready, rvalid}, 32'h0);
        chk("reset_tap", {27'h0, tap_EN, tap_WE}, 32'h0);
        chk("reset_start", {31'h0, ap_start_o}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_dlen", data_length_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of simple accesses; first read also checks rvalid hold.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, lat, en_s, we_s, ta_s, di_s);
                chk($sformatf("vec%0d_wready_lat", i), 32'(lat), 32'd1);
            end else begin
                axi_read(vecs[i].addr, (i == 0) ? 3 : 0, -1, rd, lat, ok);
                chk($sformatf("vec%0d_rvalid_lat", i), 32'(lat), 32'd3);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                chk($sformatf("vec%0d_protocol", i), {31'h0, ok}, 32'd1);
            end
        end
        chk("dlen_out", data_length_o, 32'h0000_0258);

        // Tap writes then readback.
        for (int i = 0; i < 11; i++) begin
            axi_write(12'h040 + 12'(4 * i), 32'(i + 1), lat, en_s, we_s, ta_s, di_s);
            chk($sformatf("tap%0d_port", i), {15'h0, en_s, we_s, ta_s}, {15'h0, 1'b1, 4'hF, 12'(4 * i)});
            chk($sformatf("tap%0d_di", i), di_s, 32'(i + 1));
        end
        for (int i = 0; i < 11; i++) begin
            axi_read(12'h040 + 12'(4 * i), 0, -1, rd, lat, ok);
            chk($sformatf("tap%0d_rd", i), rd, 32'(i + 1));
        end

        // Accepted start, then busy behaviour.
        axi_write(12'h000, 32'h1, lat, en_s, we_s, ta_s, di_s);
        chk("start_pulse_hi", {31'h0, ap_start_o}, 32'd1);
        @(posedge clk); #1;
        chk("start_pulse_lo", {31'h0, ap_start_o}, 32'd0);
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("busy_ctrl", rd, 32'h0);
        axi_write(12'h000, 32'h1, lat, en_s, we_s, ta_s, di_s);
        chk("restart_ack_lat", 32'(lat), 32'd1);
        chk("restart_no_pulse", {31'h0, ap_start_o}, 32'd0);
        en_before = tap_en_cnt;
        axi_read(12'h040, 0, -1, rd, lat, ok);
        chk("busy_tap_rd", rd, 32'hFFFF_FFFF);
        chk("busy_tap_no_en", 32'(tap_en_cnt - en_before), 32'd0);
        axi_read(12'h010, 0, -1, rd, lat, ok);
        chk("busy_dlen_rd", rd, 32'hFFFF_FFFF);
        axi_write(12'h010, 32'h123, lat, en_s, we_s, ta_s, di_s);
        chk("busy_dlen_wr", data_length_o, 32'h0000_0258);
        axi_write(12'h040, 32'h99, lat, en_s, we_s, ta_s, di_s);
        chk("busy_tap_wr_en", {31'h0, en_s}, 32'd0);

        // Engine done, then clear-on-read.
        engine_done_i = 1'b1;
        @(posedge clk); #1;
        engine_done_i = 1'b0;
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("done_rd1", rd, 32'h6);
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("done_rd2", rd, 32'h4);
        axi_read(12'h040, 0, -1, rd, lat, ok);
        chk("tap0_after_busy", rd, 32'h1);

        // Done coincident with the ap_ctrl read sample cycle.
        axi_write(12'h000, 32'h1, lat, en_s, we_s, ta_s, di_s);
        chk("start2_pulse", {31'h0, ap_start_o}, 32'd1);
        axi_read(12'h000, 0, 2, rd, lat, ok);
        chk("coinc_rd", rd, 32'h0);
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("coinc_next_rd", rd, 32'h6);
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("coinc_clear_rd", rd, 32'h4);

        // Simultaneous write and read: write wins, read follows.
        awaddr = 12'h010; wdata = 32'h0000_0ABC; awvalid = 1; wvalid = 1;
        araddr = 12'h010; arvalid = 1; rready = 1;
        wr_cyc = -1; rv_cyc = -1; rd = '0; ar_early = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (arready && wr_cyc < 0) ar_early = 1'b1;
            if (wready && wr_cyc < 0) begin
                wr_cyc = c;
                @(posedge clk); #1;
                c++;
                awvalid = 0; wvalid = 0;
            end
            if (rvalid) begin
                rv_cyc = c; rd = rdata;
                @(posedge clk); #1;
                break;
            end
        end
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0;
        $display("WR+RD addr=0x010 wr_cyc=%0d rv_cyc=%0d data=0x%08h", wr_cyc, rv_cyc, rd);
        chk("arb_wr_cyc", 32'(wr_cyc), 32'd1);
        chk("arb_no_early_ar", {31'h0, ar_early}, 32'd0);
        chk("arb_rv_cyc", 32'(rv_cyc), 32'd5);
        chk("arb_rdata", rd, 32'h0000_0ABC);

        // Reset while rvalid is held.
        araddr = 12'h010; arvalid = 1; rready = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_rvalid", {31'h0, rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("RST during RD_DATA rvalid=%0b rdata=0x%08h", rvalid, rdata);
        chk("rst_rvalid", {31'h0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dlen", data_length_o, 32'h0);
        arvalid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(12'h000, 0, -1, rd, lat, ok);
        chk("post_rst_ctrl", rd, 32'h4);
        chk("post_rst_lat", 32'(lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
